// File: rtl/reg_port_arbiter_pkg.sv
// Shared types and helpers for the register-port arbiter.
// Provides the arbiter FSM state encoding and an index-width helper
// used to size requester indices and the timeout counter.
package reg_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int NUM_REQ_DEFAULT = 3;

   // Bits needed to hold values 0..n-1; never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int IDX_W_DEFAULT = idx_width(NUM_REQ_DEFAULT);

endpackage

// File: rtl/reg_port_arbiter_rr_pick.sv
// Round-robin first-set-bit search starting at a pointer, wrapping mod N.
// Purely combinational: zero latency.
// Ports: i_req (request vector), i_ptr (start index), o_idx (winner), o_vld (any request).
module reg_port_arbiter_rr_pick
   import reg_port_arbiter_pkg::*;
#(
   parameter int N     = 3,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_vld
);

   // Walk the offsets from farthest to nearest so the nearest set bit
   // (smallest offset from the pointer) is the last write and wins.
   always_comb begin
      o_idx = '0;
      o_vld = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % N]) begin
            o_vld = 1'b1;
            o_idx = IDX_W'((int'(i_ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing one register-bank port among NUM_REQ requesters.
// Latency: 3 cycles minimum per transaction (grant, bank access, completion pulse).
// Ports: req_* from requesters, reg_* to/from the bank; one transaction in flight,
// reg_wait stalls the timeout, a missing reg_ack forces completion with req_err.
module reg_port_arbiter
   import reg_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 40,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT    = 4
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_REQ-1:0]            req_en,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [DATA_WIDTH-1:0]         req_rdata,
   output logic                          req_err,
   output logic [ADDR_WIDTH-1:0]         reg_addr,
   output logic                          reg_rd_en,
   output logic                          reg_wr_en,
   output logic [DATA_WIDTH-1:0]         reg_wr_data,
   output logic [STRB_WIDTH-1:0]         reg_wr_strb,
   input  logic [DATA_WIDTH-1:0]         reg_rd_data,
   input  logic                          reg_wait,
   input  logic                          reg_ack
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int CNT_W = idx_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_rr_ptr;
   logic [IDX_W-1:0]      r_grant;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_we;
   logic                  r_rd_en;
   logic                  r_wr_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic [STRB_WIDTH-1:0] r_wr_strb;
   logic [NUM_REQ-1:0]    r_ack;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;

   logic [IDX_W-1:0]      w_pick_idx;
   logic                  w_pick_vld;
   logic                  w_start;
   logic                  w_done_ok;
   logic                  w_done_to;
   logic                  w_cnt_dec;
   logic                  w_sel_we;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;
   logic [STRB_WIDTH-1:0] w_sel_wstrb;

   reg_port_arbiter_rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .i_req (req_en),
      .i_ptr (r_rr_ptr),
      .o_idx (w_pick_idx),
      .o_vld (w_pick_vld)
   );

   assign w_sel_we    = req_we[w_pick_idx];
   assign w_sel_addr  = req_addr[int'(w_pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign w_sel_wdata = req_wdata[int'(w_pick_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign w_sel_wstrb = req_wstrb[int'(w_pick_idx)*STRB_WIDTH +: STRB_WIDTH];

   // Next-state and control decode.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_done_ok   = 1'b0;
      w_done_to   = 1'b0;
      w_cnt_dec   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_vld) begin
               w_start     = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // A bank ack always wins; reg_wait only matters without one.
            if (reg_ack) begin
               w_done_ok   = 1'b1;
               w_state_nxt = ST_DONE;
            end else if (!reg_wait) begin
               if (r_cnt == '0) begin
                  w_done_to   = 1'b1;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_cnt_dec = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rr_ptr  <= '0;
         r_grant   <= '0;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_rd_en   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_addr    <= '0;
         r_wr_data <= '0;
         r_wr_strb <= '0;
         r_ack     <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
      end else begin
         r_ack <= '0;
         if (w_start) begin
            r_grant   <= w_pick_idx;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wr_data <= w_sel_wdata;
            r_wr_strb <= w_sel_wstrb;
            r_cnt     <= CNT_LOAD;
            r_rd_en   <= !w_sel_we;
            r_wr_en   <= w_sel_we;
         end
         if (w_cnt_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_done_ok || w_done_to) begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_ack   <= NUM_REQ'(1) << r_grant;
            r_err   <= w_done_to;
            // Writes and timeouts report zero data.
            r_rdata <= (w_done_ok && !r_we) ? reg_rd_data : '0;
         end
         // The requester just served drops to lowest priority.
         if (r_state == ST_DONE) begin
            r_rr_ptr <= (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);
         end
      end
   end

   assign req_ack     = r_ack;
   assign req_rdata   = r_rdata;
   assign req_err     = r_err;
   assign reg_addr    = r_addr;
   assign reg_rd_en   = r_rd_en;
   assign reg_wr_en   = r_wr_en;
   assign reg_wr_data = r_wr_data;
   assign reg_wr_strb = r_wr_strb;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed self-checking bench for reg_port_arbiter.
// Drives inputs and samples outputs 1 time unit after each rising edge.
// Each scenario task does its own comparisons against hand-computed values.
module tb_reg_port_arbiter;

   localparam int NR = 3;
   localparam int AW = 40;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 4;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic [NR-1:0]    req_en = '0;
   logic [NR-1:0]    req_we = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [NR*SW-1:0] req_wstrb = '0;
   logic [NR-1:0]    req_ack;
   logic [DW-1:0]    req_rdata;
   logic             req_err;
   logic [AW-1:0]    reg_addr;
   logic             reg_rd_en;
   logic             reg_wr_en;
   logic [DW-1:0]    reg_wr_data;
   logic [SW-1:0]    reg_wr_strb;
   logic [DW-1:0]    reg_rd_data = '0;
   logic             reg_wait = 1'b0;
   logic             reg_ack = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   reg_port_arbiter #(
      .NUM_REQ    (NR),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .STRB_WIDTH (SW),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_en      (req_en),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_wstrb   (req_wstrb),
      .req_ack     (req_ack),
      .req_rdata   (req_rdata),
      .req_err     (req_err),
      .reg_addr    (reg_addr),
      .reg_rd_en   (reg_rd_en),
      .reg_wr_en   (reg_wr_en),
      .reg_wr_data (reg_wr_data),
      .reg_wr_strb (reg_wr_strb),
      .reg_rd_data (reg_rd_data),
      .reg_wait    (reg_wait),
      .reg_ack     (reg_ack)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      step();
      step();
      n_tests++;
      if (req_ack !== 3'b000) begin
         n_fail++; $display("FAIL reset_req_ack got %b want 000", req_ack);
      end
      n_tests++;
      if (reg_rd_en !== 1'b0 || reg_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL reset_en got rd=%b wr=%b want 0 0", reg_rd_en, reg_wr_en);
      end
      n_tests++;
      if (reg_addr !== 40'h0 || reg_wr_data !== 32'h0 || reg_wr_strb !== 4'h0) begin
         n_fail++; $display("FAIL reset_reg_bus got addr=%h wd=%h ws=%h want 0", reg_addr, reg_wr_data, reg_wr_strb);
      end
      n_tests++;
      if (req_rdata !== 32'h0 || req_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_resp got rdata=%h err=%b want 0 0", req_rdata, req_err);
      end
      rstn = 1'b1;
   endtask

   // Requester 1 read, bank acks in the first BUSY cycle. rr_ptr becomes 2.
   task automatic test_single_read();
      req_addr[1*AW +: AW] = 40'h10;
      req_we      = 3'b000;
      reg_rd_data = 32'hA5A5A5A5;
      reg_ack     = 1'b1;
      req_en      = 3'b010;
      step();
      n_tests++;
      if (reg_rd_en !== 1'b1 || reg_wr_en !== 1'b0 || reg_addr !== 40'h10) begin
         n_fail++; $display("FAIL read_busy got rd=%b wr=%b addr=%h want 1 0 10", reg_rd_en, reg_wr_en, reg_addr);
      end
      n_tests++;
      if (req_ack !== 3'b000) begin
         n_fail++; $display("FAIL read_early_ack got %b want 000", req_ack);
      end
      step();
      req_en = 3'b000;
      n_tests++;
      if (req_ack !== 3'b010 || req_rdata !== 32'hA5A5A5A5 || req_err !== 1'b0) begin
         n_fail++; $display("FAIL read_done got ack=%b rdata=%h err=%b want 010 a5a5a5a5 0", req_ack, req_rdata, req_err);
      end
      n_tests++;
      if (reg_rd_en !== 1'b0) begin
         n_fail++; $display("FAIL read_rd_en_width got %b want 0", reg_rd_en);
      end
      step();
      n_tests++;
      if (req_ack !== 3'b000) begin
         n_fail++; $display("FAIL read_ack_width got %b want 000", req_ack);
      end
   endtask

   // Requester 2 write, drops req_en right after the grant. rr_ptr becomes 0.
   task automatic test_write();
      req_addr[2*AW +: AW]  = 40'h20;
      req_wdata[2*DW +: DW] = 32'h12345678;
      req_wstrb[2*SW +: SW] = 4'b0011;
      req_we  = 3'b100;
      reg_ack = 1'b1;
      req_en  = 3'b100;
      step();
      req_en = 3'b000;
      req_we = 3'b000;
      n_tests++;
      if (reg_wr_en !== 1'b1 || reg_rd_en !== 1'b0) begin
         n_fail++; $display("FAIL write_en got wr=%b rd=%b want 1 0", reg_wr_en, reg_rd_en);
      end
      n_tests++;
      if (reg_wr_data !== 32'h12345678 || reg_wr_strb !== 4'b0011 || reg_addr !== 40'h20) begin
         n_fail++; $display("FAIL write_bus got wd=%h ws=%b addr=%h want 12345678 0011 20", reg_wr_data, reg_wr_strb, reg_addr);
      end
      step();
      n_tests++;
      if (req_ack !== 3'b100 || req_rdata !== 32'h0 || req_err !== 1'b0) begin
         n_fail++; $display("FAIL write_done got ack=%b rdata=%h err=%b want 100 0 0", req_ack, req_rdata, req_err);
      end
      step();
   endtask

   // Requester 0 read with a silent bank: 4 BUSY cycles then forced completion.
   task automatic test_timeout();
      int busy = 0;
      bit got = 0;
      bit addr_bad = 0;
      logic [NR-1:0] ack_v = '0;
      logic [DW-1:0] rdata_v = '1;
      logic err_v = 1'b0;
      reg_ack     = 1'b0;
      reg_wait    = 1'b0;
      reg_rd_data = 32'hDEADBEEF;
      req_addr[0*AW +: AW] = 40'hAB_CDEF_0123;
      req_en = 3'b001;
      for (int c = 0; c < 20 && !got; c++) begin
         step();
         if (c == 0) begin
            req_en = 3'b000;
            req_addr[0*AW +: AW] = 40'h1;
         end
         if (reg_rd_en) begin
            busy++;
            if (reg_addr !== 40'hAB_CDEF_0123) addr_bad = 1;
         end
         if (req_ack !== 3'b000) begin
            got = 1; ack_v = req_ack; rdata_v = req_rdata; err_v = req_err;
         end
      end
      n_tests++;
      if (busy != 4) begin
         n_fail++; $display("FAIL timeout_busy_cycles got %0d want 4", busy);
      end
      n_tests++;
      if (ack_v !== 3'b001 || err_v !== 1'b1 || rdata_v !== 32'h0) begin
         n_fail++; $display("FAIL timeout_done got ack=%b err=%b rdata=%h want 001 1 0", ack_v, err_v, rdata_v);
      end
      n_tests++;
      if (addr_bad) begin
         n_fail++; $display("FAIL timeout_addr_stable got changed want ab_cdef_0123");
      end
      step();
   endtask

   // Requester 1 read, reg_wait high for the first 10 BUSY cycles: 14 BUSY cycles total.
   task automatic test_wait();
      int busy = 0;
      bit got = 0;
      logic [NR-1:0] ack_v = '0;
      logic err_v = 1'b0;
      reg_ack  = 1'b0;
      reg_wait = 1'b1;
      req_en   = 3'b010;
      for (int c = 0; c < 40 && !got; c++) begin
         step();
         if (c == 0) req_en = 3'b000;
         if (reg_rd_en) busy++;
         reg_wait = (busy <= 10);
         if (req_ack !== 3'b000) begin
            got = 1; ack_v = req_ack; err_v = req_err;
         end
      end
      reg_wait = 1'b0;
      n_tests++;
      if (busy != 14) begin
         n_fail++; $display("FAIL wait_busy_cycles got %0d want 14", busy);
      end
      n_tests++;
      if (ack_v !== 3'b010 || err_v !== 1'b1) begin
         n_fail++; $display("FAIL wait_done got ack=%b err=%b want 010 1", ack_v, err_v);
      end
      step();
   endtask

   // rr_ptr is 2 here; reset mid-BUSY must clear it so {1,2} pending picks 1.
   task automatic test_reset_mid();
      bit ack_seen = 0;
      reg_ack = 1'b0;
      req_we  = 3'b000;
      req_addr[1*AW +: AW] = 40'h11;
      req_addr[2*AW +: AW] = 40'h22;
      req_en = 3'b100;
      step();
      step();
      n_tests++;
      if (reg_rd_en !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_pre_busy got rd=%b want 1", reg_rd_en);
      end
      rstn = 1'b0;
      req_en = 3'b000;
      #1;
      n_tests++;
      if (reg_rd_en !== 1'b0 || reg_wr_en !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_async_drop got rd=%b wr=%b want 0 0", reg_rd_en, reg_wr_en);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         if (req_ack !== 3'b000) ack_seen = 1;
      end
      n_tests++;
      if (ack_seen) begin
         n_fail++; $display("FAIL rstmid_no_ack got ack pulse want none");
      end
      rstn    = 1'b1;
      reg_ack = 1'b1;
      req_en  = 3'b110;
      step();
      req_en = 3'b000;
      n_tests++;
      if (reg_rd_en !== 1'b1 || reg_addr !== 40'h11) begin
         n_fail++; $display("FAIL rstmid_regrant got rd=%b addr=%h want 1 11", reg_rd_en, reg_addr);
      end
      step();
      n_tests++;
      if (req_ack !== 3'b010) begin
         n_fail++; $display("FAIL rstmid_ack got %b want 010", req_ack);
      end
      step();
   endtask

   // All requests held from reset, bank always acks: grants 0,1,2,0,1,2 every 3 cycles.
   task automatic test_round_robin();
      int n = 0;
      int last_cyc = 0;
      int cyc = 0;
      logic [NR-1:0] exp_ack;
      rstn     = 1'b0;
      req_we   = 3'b000;
      reg_ack  = 1'b1;
      reg_wait = 1'b0;
      req_en   = 3'b111;
      step();
      rstn = 1'b1;
      for (int c = 0; c < 40 && n < 6; c++) begin
         step();
         cyc++;
         if (req_ack !== 3'b000) begin
            exp_ack = 3'b001 << (n % 3);
            n_tests++;
            if (req_ack !== exp_ack) begin
               n_fail++; $display("FAIL rr_grant%0d got %b want %b", n, req_ack, exp_ack);
            end
            if (n > 0) begin
               n_tests++;
               if (cyc - last_cyc != 3) begin
                  n_fail++; $display("FAIL rr_gap%0d got %0d want 3", n, cyc - last_cyc);
               end
            end
            last_cyc = cyc;
            n++;
            if (n == 6) req_en = 3'b000;
         end
      end
      n_tests++;
      if (n != 6) begin
         n_fail++; $display("FAIL rr_count got %0d want 6", n);
      end
      step();
      step();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write();
      test_timeout();
      test_wait();
      test_reset_mid();
      test_round_robin();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
